thermo_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among 16 requesters, using the team's thermometer-mask / one-hot-grant datapath style. A thermometer mask derived from the last-granted index sets rotating priority, and the grant is a registered one-hot vector. The arbiter holds each grant until release, requester withdrawal or hold timeout. It sits in front of any shared combinational unit, such as a converter or bus port, that serves one client at a time.

---
 rtl/thermo_rr_arbiter.sv | 90 +++++++++
 tb/tb_thermo_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_rr_arbiter.sv
// 16-way round-robin arbiter: thermometer mask above the last-granted index sets
// rotating priority; registered one-hot grant held until done, withdrawal or hold limit.
//
// state | meaning
// IDLE  | no grant active; arbitrate req each cycle
// BUSY  | grant_idx owns the resource; watch done / req withdrawal / hold limit
module thermo_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic        grant_valid,
    output logic [3:0]  grant_idx,
    output logic        timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state;
    logic [3:0]  ptr;
    logic [7:0]  hold_cnt;
    logic [15:0] mask;
    logic [15:0] masked;
    logic [15:0] pick;
    logic [3:0]  win_idx;

    // Priority starts just above the last winner; fall back to plain lowest-index
    // when nothing above it is requesting.
    always_comb begin
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            mask[i] = (i > int'(ptr));
        end
        masked  = req & mask;
        pick    = (masked != '0) ? masked : req;
        win_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pick[i]) win_idx = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 4'd15;
            hold_cnt    <= 8'd0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= 4'd0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        grant       <= 16'd1 << win_idx;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= 8'd0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (done || !req[grant_idx]) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx;
                        state       <= IDLE;
                    end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx;
                        timeout     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thermo_rr_arbiter.sv
// Directed bench for thermo_rr_arbiter: stimulus pushes expected grants into a
// scoreboard; a negedge monitor checks each grant's vector, length, gap and timeout.
module tb_thermo_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic        timeout;

    thermo_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] g;
        logic [3:0]  idx;
        int          len;
        bit          to;
        int          gap;   // -1: don't care
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 0;
    bit   prev_valid = 0;
    int   cur_len = 0;
    int   idle_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int len, input bit to, input int gap);
        exp_t e;
        e.g   = 16'd1 << idx;
        e.idx = 4'(idx);
        e.len = len;
        e.to  = to;
        e.gap = gap;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        chk("onehot", 32'($countones(grant) <= 1), 32'd1);
        chk("valid_vs_grant", 32'(grant_valid), 32'(grant != 16'd0));
        if (grant_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                have_cur = 0;
                $display("FAIL unexpected_grant: got 0x%0h, expected none", grant);
            end else begin
                cur = sb.pop_front();
                have_cur = 1;
                chk("grant", 32'(grant), 32'(cur.g));
                chk("grant_idx", 32'(grant_idx), 32'(cur.idx));
                if (cur.gap >= 0) chk("idle_gap", 32'(idle_cnt), 32'(cur.gap));
            end
            cur_len = 1;
        end else if (grant_valid) begin
            cur_len++;
        end else if (prev_valid) begin
            if (have_cur) begin
                chk("grant_len", 32'(cur_len), 32'(cur.len));
                chk("timeout_at_release", 32'(timeout), 32'(cur.to));
            end
            have_cur = 0;
            idle_cnt = 1;
        end else begin
            idle_cnt++;
        end
        prev_valid = (grant_valid === 1'b1);
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(input string name);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (grant_valid !== 1'b1 && k < 40);
        if (grant_valid !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no grant within 40 cycles, got valid=%b, expected 1", name, grant_valid);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (grant_valid === 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (grant_valid !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: grant still active after 40 cycles, expected release", name);
        end
    endtask

    task automatic done_in_cycle(input int n);
        cycles(n - 1);
        done = 1'b1;
        cycles(1);
        done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 16'h0000;
        done = 1'b0;
        cycles(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            chk("idle_grant", 32'(grant), 32'h0);
            chk("idle_valid", 32'(grant_valid), 32'h0);
            chk("idle_idx", 32'(grant_idx), 32'h0);
            chk("idle_timeout", 32'(timeout), 32'h0);
        end

        // Two-way rotation
        push(0, 2, 0, -1);
        push(4, 2, 0, 1);
        push(0, 2, 0, 1);
        push(4, 2, 0, 1);
        req = 16'h0011;
        for (int i = 0; i < 4; i++) begin
            wait_grant("rot");
            done_in_cycle(2);
        end
        req = 16'h0000;
        cycles(3);

        // Mask wrap from ptr=4
        push(15, 2, 0, -1);
        push(0, 2, 0, 1);
        push(3, 2, 0, 1);
        req = 16'h8009;
        for (int i = 0; i < 3; i++) begin
            wait_grant("wrap");
            done_in_cycle(2);
        end
        req = 16'h0000;
        cycles(3);

        // Hold limit, then done coinciding with limit, then withdrawal
        push(1, 4, 1, -1);
        push(1, 4, 0, 1);
        push(1, 1, 0, 1);
        req = 16'h0002;
        wait_grant("hold_a");
        wait_idle("hold_a");
        chk("timeout_pulse", 32'(timeout), 32'h1);
        wait_grant("hold_b");
        chk("timeout_one_cycle", 32'(timeout), 32'h0);
        done_in_cycle(4);
        wait_grant("hold_c");
        req = 16'h0000;
        cycles(1);
        chk("withdraw_no_timeout", 32'(timeout), 32'h0);
        cycles(2);

        // Withdrawal of idx 7, done while idle, then mask fallback
        push(7, 2, 0, -1);
        req = 16'h0080;
        wait_grant("wd7");
        cycles(1);
        req = 16'h0000;
        cycles(1);
        chk("wd7_grant_low", 32'(grant), 32'h0);
        chk("wd7_timeout", 32'(timeout), 32'h0);
        for (int i = 0; i < 3; i++) begin
            done = 1'b1;
            cycles(1);
            done = 1'b0;
            chk("idle_done_grant", 32'(grant), 32'h0);
            chk("idle_done_idx", 32'(grant_idx), 32'h7);
            chk("idle_done_timeout", 32'(timeout), 32'h0);
            cycles(1);
        end
        push(0, 2, 0, -1);
        req = 16'h0081;
        wait_grant("fallback");
        done_in_cycle(2);
        req = 16'h0000;
        cycles(3);

        // Reset mid-grant, then full fairness sweep
        push(10, 2, 0, -1);
        req = 16'h0400;
        wait_grant("pre_rst");
        cycles(1);
        rst = 1'b1;
        cycles(1);
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_valid", 32'(grant_valid), 32'h0);
        chk("midrst_idx", 32'(grant_idx), 32'h0);
        chk("midrst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) push(i, 2, 0, (i == 0) ? -1 : 1);
        req = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            wait_grant("fair");
            done_in_cycle(2);
        end
        req = 16'h0000;
        cycles(5);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
